// File: rtl/fetch_npc_unit.sv
// fetch_npc_unit: instruction-fetch and next-PC stage feeding the control decoder.
// Holds the architectural PC, fetches one instruction word over a req/ack
// handshake, issues it to the decoder, then advances the PC from the
// decoder's Jump/Branch outputs, the ALU Zero flag and the instruction immediates.
//
// Ports:
//   clk, rstn                 clock (rising edge), async active-low reset
//   Jump[1:0], Branch[1:0]    decoder control (0 none, 1 imm26 jump / beq, 2 reg jump / bne, 3 reserved)
//   Zero                      ALU zero flag for the issued instruction
//   RegTarget[31:0]           rs value for jr/jalr
//   stall                     datapath hold request while issuing
//   imem_req, imem_addr       instruction-memory request and address (= pc)
//   imem_ack, imem_rdata      instruction-memory data valid and word
//   instr, instr_valid        issued instruction and its valid
//   pc, pc_plus4              current PC and link value
//   retired                   retired-instruction counter (wraps)
//   misalign_err              sticky misaligned register-jump flag
module fetch_npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  Jump,
  input  logic [1:0]  Branch,
  input  logic        Zero,
  input  logic [31:0] RegTarget,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;

  // Low bits forced to zero so pc stays word-aligned even with a bad override.
  localparam logic [XLEN-1:0] RESET_PC_W = {RESET_PC[XLEN-1:2], 2'b00};

  localparam logic [1:0] J_IMM  = 2'd1;
  localparam logic [1:0] J_REG  = 2'd2;
  localparam logic [1:0] J_NONE = 2'd0;
  localparam logic [1:0] B_EQ   = 2'd1;
  localparam logic [1:0] B_NE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] br_off;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Next-PC select; jumps win over branches, reserved encodings fall through to pc+4.
  always_comb begin
    br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    npc    = pc_plus4;
    if (Jump == J_IMM) begin
      npc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (Jump == J_REG) begin
      npc = {RegTarget[31:2], 2'b00};
    end else if (Jump == J_NONE &&
                 ((Branch == B_EQ && Zero) || (Branch == B_NE && !Zero))) begin
      npc = pc_plus4 + br_off;
    end
  end

  // Fetch/issue sequencer with registered handshake and issue outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      pc           <= RESET_PC_W;
      instr        <= '0;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      retired      <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= ISSUE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          // Control inputs only matter on the edge that retires the instruction.
          if (!stall) begin
            pc          <= npc;
            retired     <= retired + 32'd1;
            state       <= FETCH;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            if (Jump == J_REG && RegTarget[1:0] != 2'b00) begin
              misalign_err <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Self-checking bench for fetch_npc_unit: directed cases from the feature list
// followed by randomized instructions, all compared against a transaction-level
// model of the PC, retired counter and misalign flag.
module tb_fetch_npc_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  Jump, Branch;
  logic        Zero;
  logic [31:0] RegTarget;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4, retired;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [31:0] m_pc, m_ret, m_instr;
  logic        m_mis;

  always #5 clk = ~clk;

  fetch_npc_unit dut (
    .clk(clk), .rstn(rstn), .Jump(Jump), .Branch(Branch), .Zero(Zero),
    .RegTarget(RegTarget), .stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .retired(retired), .misalign_err(misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Next PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [31:0] word,
                                          input logic [1:0] j, input logic [1:0] b,
                                          input logic z, input logic [31:0] rt);
    logic [31:0] seq, off;
    seq = cur + 32'd4;
    off = {{16{word[15]}}, word[15:0]};
    if (j == 2'd1) return {seq[31:28], word[25:0], 2'b00};
    if (j == 2'd2) return rt - 32'(rt % 4);
    if (j == 2'd0 && ((b == 2'd1 && z) || (b == 2'd2 && !z))) return seq + off * 32'd4;
    return seq;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_ret = 0; m_instr = 0; m_mis = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0000_3000);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_ivalid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_ret"}, retired, 32'h0);
    chk({tag, "_mis"}, 32'(misalign_err), 32'h0);
  endtask

  // Assert reset at a negedge (async), offer a stray ack, then release.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rstn = 1'b0; imem_ack = 1'b1; imem_rdata = $urandom;
    #1 chk_reset(tag);
    @(negedge clk);
    chk_reset({tag, "_hold"});
    rstn = 1'b1; imem_ack = 1'b0; stall = 1'b0;
    model_reset();
  endtask

  // One instruction: w wait states in fetch, s stall cycles in issue.
  task automatic run_instr(input int w, input int s, input logic [31:0] word,
                           input logic [1:0] j, input logic [1:0] b,
                           input logic z, input logic [31:0] rt);
    for (int k = 0; k <= w; k++) begin
      @(negedge clk);
      chk("f_req", 32'(imem_req), 32'h1);
      chk("f_addr", imem_addr, m_pc);
      chk("f_ivalid", 32'(instr_valid), 32'h0);
      chk("f_instr_hold", instr, m_instr);
      imem_ack   = (k == w);
      imem_rdata = (k == w) ? word : $urandom;
    end
    m_instr = word;
    for (int k = 0; k <= s; k++) begin
      @(negedge clk);
      chk("i_ivalid", 32'(instr_valid), 32'h1);
      chk("i_req", 32'(imem_req), 32'h0);
      chk("i_instr", instr, word);
      chk("i_pc", pc, m_pc);
      chk("i_pc4", pc_plus4, m_pc + 32'd4);
      chk("i_ret", retired, m_ret);
      chk("i_mis", 32'(misalign_err), 32'(m_mis));
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      stall      = (k < s);
      if (k < s) begin
        Jump = 2'($urandom); Branch = 2'($urandom); Zero = 1'($urandom); RegTarget = $urandom;
      end else begin
        Jump = j; Branch = b; Zero = z; RegTarget = rt;
      end
    end
    m_pc = ref_npc(m_pc, word, j, b, z, rt);
    m_ret = m_ret + 32'd1;
    if (j == 2'd2 && rt[1:0] != 2'b00) m_mis = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; Jump = 0; Branch = 0; Zero = 0; RegTarget = 0; stall = 0;
    imem_ack = 0; imem_rdata = 0;
    model_reset();
    do_reset("rst0");

    // First fetch with immediate ack, then a 3-cycle wait-state fetch.
    run_instr(0, 0, 32'h0000_0000, 2'd0, 2'd0, 1'b0, 32'h0);
    run_instr(3, 0, 32'h1234_5678, 2'd0, 2'd0, 1'b0, 32'h0);
    // Branches at 0x3010 with imm16 = 0xFFFC.
    run_instr(0, 0, 32'h0, 2'd2, 2'd0, 1'b0, 32'h0000_3010);
    run_instr(0, 0, 32'h1000_FFFC, 2'd0, 2'd1, 1'b1, 32'h0);
    chk("beq_taken", m_pc, 32'h0000_3004);
    run_instr(0, 0, 32'h0, 2'd2, 2'd0, 1'b0, 32'h0000_3010);
    run_instr(0, 0, 32'h1000_FFFC, 2'd0, 2'd1, 1'b0, 32'h0);
    run_instr(0, 0, 32'h0, 2'd2, 2'd0, 1'b0, 32'h0000_3010);
    run_instr(1, 0, 32'h1400_FFFC, 2'd0, 2'd2, 1'b0, 32'h0);
    // Imm26 jump from 0x3000, then a misaligned register jump.
    run_instr(0, 0, 32'h0, 2'd2, 2'd0, 1'b0, 32'h0000_3000);
    run_instr(0, 0, 32'h0800_0C10, 2'd1, 2'd1, 1'b1, 32'h0);
    run_instr(0, 0, 32'h0, 2'd2, 2'd0, 1'b0, 32'h0000_3022);
    // 4-cycle stall, reserved encodings, then wrap from 0xFFFF_FFFC.
    run_instr(0, 4, 32'hABCD_0001, 2'd3, 2'd3, 1'b1, 32'h0);
    run_instr(0, 0, 32'h0, 2'd2, 2'd0, 1'b0, 32'hFFFF_FFFC);
    run_instr(2, 1, 32'h1000_0010, 2'd0, 2'd2, 1'b1, 32'h0);
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("mis_sticky", 32'(misalign_err), 32'h1);
    imem_ack = 1'b0;

    // Reset mid-fetch aborts the pending request.
    do_reset("rst_mid");
    run_instr(0, 0, 32'h0, 2'd0, 2'd0, 1'b0, 32'h0);

    // Randomized instructions; register jumps kept mostly aligned.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] rt;
      rt = $urandom;
      if ($urandom_range(0, 7) != 0) rt[1:0] = 2'b00;
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom,
                2'($urandom), 2'($urandom), 1'($urandom), rt);
      if (n == 150) begin
        @(negedge clk);
        imem_ack = 1'b0;
        do_reset("rst_rand");
      end
    end
    @(negedge clk);
    chk("end_addr", imem_addr, m_pc);
    chk("end_ret", retired, m_ret);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
